coproc_controller: RTL and testbench
====================================

// Module: coproc_controller
// PURPOSE
//   Sequencer for the 5x5 matrix ULA of the coprocessor. Accepts one instruction
//   (opcode, scalar, three base addresses) and loads matrix A and matrix B
//   bytewise from the shared 8-bit data memory. Runs the ULA start/done
//   handshake, then writes the 200-bit result back to memory. Sits between the
//   instruction interface and the ULA/memory.
// PARAMETERS
//   ADDR_W   9    data memory address width (byte addresses)
//   N_ELEM   25   matrix elements per operand; byte k maps to bits [8k+:8]
//   TIMEOUT  255  max EXEC cycles waiting for ula_done before aborting
// PORTS
//   clk            in   1        system clock, all logic on rising edge
//   reset          in   1        synchronous, active-high reset
//   instr_valid    in   1        instruction present
//   instr_ready    out  1        controller can accept (high only in IDLE)
//   instr_opcode   in   4        0=NOP, else forwarded to ULA
//   instr_escalar  in   8        scalar operand, forwarded to ULA
//   instr_addr_a   in   ADDR_W   base address of matrix A
//   instr_addr_b   in   ADDR_W   base address of matrix B
//   instr_addr_r   in   ADDR_W   base address of the result
//   mem_addr       out  ADDR_W   memory address
//   mem_rd         out  1        read strobe; mem_rdata valid the following cycle
//   mem_wr         out  1        write strobe, writes mem_wdata at mem_addr
//   mem_wdata      out  8        write data
//   mem_rdata      in   8        read data (1-cycle latency)
//   ula_start      out  1        ULA start, level, held until done seen
//   ula_opcode     out  4        latched opcode
//   ula_escalar    out  8        latched scalar
//   ula_matriz_a   out  200      loaded matrix A
//   ula_matriz_b   out  200      loaded matrix B
//   ula_resultado  in   200      ULA result
//   ula_done       in   1        ULA done
//   busy           out  1        high in every state except IDLE
//   cmd_done       out  1        one-cycle pulse at end of each instruction
//   error          out  1        timeout flag, valid with cmd_done, held until next accept
// BEHAVIOUR
//   Reset: state=IDLE; mem_rd, mem_wr, ula_start, cmd_done, error, busy = 0;
//     mem_addr, mem_wdata, ula_* outputs and internal matrices = 0. Aborts any
//     operation; no memory write occurs in the cycle after reset is sampled.
//   FSM: IDLE -> LOAD_A -> LOAD_B -> EXEC -> STORE -> DONE -> IDLE.
//   IDLE: instr_ready=1. On instr_valid&instr_ready, latch all instr_* fields
//     and clear error. If opcode==0, go to DONE with no memory/ULA traffic.
//     Otherwise go to LOAD_A with idx=0. instr_valid is ignored outside IDLE.
//   LOAD_A/LOAD_B: 26 cycles each, idx runs 0..N_ELEM.
//     For idx<N_ELEM: mem_rd=1, mem_addr=base+idx, mod 2^ADDR_W (wraps).
//     For idx>=1: capture mem_rdata into byte idx-1.
//     At idx==N_ELEM: mem_rd=0, advance state, reset idx to 0.
//   EXEC: ula_start=1. ula_done is ignored in the first EXEC cycle (stale-done
//     guard). On a later cycle with ula_done=1: latch ula_resultado, drop
//     ula_start, go to STORE. If TIMEOUT cycles pass without done: drop
//     ula_start, set error=1, go to DONE (no store).
//   STORE: 25 cycles. mem_wr=1, mem_addr=addr_r+idx (wraps),
//     mem_wdata=result[8*idx+:8].
//   DONE: cmd_done=1 for exactly one cycle, then go to IDLE.
//   ula_start is low in every state except EXEC. The ULA clears its done when
//     start is low, so back-to-back instructions are safe.
//   mem_rd and mem_wr are never high in the same cycle.
//   Latency (ULA answers 1 cycle after start), counted from the cycle after
//     acceptance: LOAD_A 26 + LOAD_B 26 + EXEC 2 + STORE 25 + DONE 1.
//     cmd_done is high in cycle 80. NOP: cmd_done in cycle 1.
// TESTING
//   Reset, then idle 5 cycles -> instr_ready=1, busy=0, no mem_rd/mem_wr/ula_start.
//   Add: opcode=1, A[k]=k at 0x000, B[k]=2k at 0x020, addr_r=0x040 -> mem[0x40+k]=3k
//     for k=0..24; cmd_done exactly at cycle 80; error=0.
//   Wrap: addr_a=0x1F0 (ADDR_W=9) -> reads 0x1F0..0x1FF, then 0x000..0x008.
//   NOP: opcode=0 -> cmd_done in cycle 1, zero mem strobes, ula_start never high.
//   Timeout: ula_done tied to 0 -> ula_start high for 255 cycles, then cmd_done
//     with error=1 and no mem_wr.
//   Reset asserted mid-STORE (idx=10) -> mem_wr=0 from the next cycle, state IDLE;
//     a new instruction then completes normally.

Source files
------------

// File: rtl/coproc_controller.sv
// Sequencer for the 5x5 matrix ULA. Takes one instruction, loads matrices A and B
// bytewise from the 8-bit data memory, runs the ULA start/done handshake and
// stores the 200-bit result back to memory.
// Ports: instruction handshake (instr_*), byte memory port (mem_*, 1-cycle read
//   latency), ULA interface (ula_*), status (busy, cmd_done, error).
module coproc_controller #(
  parameter int ADDR_W  = 9,
  parameter int N_ELEM  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  // instruction interface
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          instr_opcode,
  input  logic [7:0]          instr_escalar,
  input  logic [ADDR_W-1:0]   instr_addr_a,
  input  logic [ADDR_W-1:0]   instr_addr_b,
  input  logic [ADDR_W-1:0]   instr_addr_r,
  // data memory
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  // ULA
  output logic                ula_start,
  output logic [3:0]          ula_opcode,
  output logic [7:0]          ula_escalar,
  output logic [8*N_ELEM-1:0] ula_matriz_a,
  output logic [8*N_ELEM-1:0] ula_matriz_b,
  input  logic [8*N_ELEM-1:0] ula_resultado,
  input  logic                ula_done,
  // status
  output logic                busy,
  output logic                cmd_done,
  output logic                error
);

  localparam int IDX_W = $clog2(N_ELEM + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int MW    = 8 * N_ELEM;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [7:0]        escalar_q, escalar_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_r_q, addr_r_d;
  logic [MW-1:0]     mat_a_q, mat_a_d;
  logic [MW-1:0]     mat_b_q, mat_b_d;
  logic [MW-1:0]     res_q, res_d;
  logic              error_q, error_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    exec_cnt_d = exec_cnt_q;
    opcode_d   = opcode_q;
    escalar_d  = escalar_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_r_d   = addr_r_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    res_d      = res_q;
    error_d    = error_q;

    instr_ready = 1'b0;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    ula_start   = 1'b0;
    cmd_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          opcode_d   = instr_opcode;
          escalar_d  = instr_escalar;
          addr_a_d   = instr_addr_a;
          addr_b_d   = instr_addr_b;
          addr_r_d   = instr_addr_r;
          error_d    = 1'b0;
          idx_d      = '0;
          exec_cnt_d = '0;
          state_d    = (instr_opcode == 4'd0) ? S_DONE : S_LOAD_A;
        end
      end

      S_LOAD_A, S_LOAD_B: begin
        // Issue read for byte idx; data for byte idx-1 arrives this cycle.
        if (idx_q < IDX_W'(N_ELEM)) begin
          mem_rd   = 1'b1;
          mem_addr = ((state_q == S_LOAD_A) ? addr_a_q : addr_b_q) + ADDR_W'(idx_q);
        end
        for (int k = 0; k < N_ELEM; k++) begin
          if (idx_q == IDX_W'(k + 1)) begin
            if (state_q == S_LOAD_A) mat_a_d[8*k +: 8] = mem_rdata;
            else                     mat_b_d[8*k +: 8] = mem_rdata;
          end
        end
        if (idx_q == IDX_W'(N_ELEM)) begin
          idx_d   = '0;
          state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_EXEC;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_EXEC: begin
        ula_start = 1'b1;
        // First EXEC cycle ignores done: it may still reflect a previous command.
        if (exec_cnt_q != '0 && ula_done) begin
          res_d   = ula_resultado;
          idx_d   = '0;
          state_d = S_STORE;
        end else if (exec_cnt_q == TO_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end

      S_STORE: begin
        mem_wr   = 1'b1;
        mem_addr = addr_r_q + ADDR_W'(idx_q);
        for (int k = 0; k < N_ELEM; k++) begin
          if (idx_q == IDX_W'(k)) mem_wdata = res_q[8*k +: 8];
        end
        if (idx_q == IDX_W'(N_ELEM - 1)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        cmd_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      exec_cnt_q <= '0;
      opcode_q   <= '0;
      escalar_q  <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_r_q   <= '0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      res_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      exec_cnt_q <= exec_cnt_d;
      opcode_q   <= opcode_d;
      escalar_q  <= escalar_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_r_q   <= addr_r_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      res_q      <= res_d;
      error_q    <= error_d;
    end
  end

  assign ula_opcode   = opcode_q;
  assign ula_escalar  = escalar_q;
  assign ula_matriz_a = mat_a_q;
  assign ula_matriz_b = mat_b_q;
  assign busy         = (state_q != S_IDLE);
  assign error        = error_q;

endmodule

// File: tb/tb_coproc_controller.sv
module tb_coproc_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [3:0]   instr_opcode = '0;
  logic [7:0]   instr_escalar = '0;
  logic [8:0]   instr_addr_a = '0, instr_addr_b = '0, instr_addr_r = '0;
  logic [8:0]   mem_addr;
  logic         mem_rd, mem_wr;
  logic [7:0]   mem_wdata;
  logic [7:0]   mem_rdata = '0;
  logic         ula_start;
  logic [3:0]   ula_opcode;
  logic [7:0]   ula_escalar;
  logic [199:0] ula_matriz_a, ula_matriz_b;
  logic [199:0] ula_resultado;
  logic         ula_done = 1'b0;
  logic         busy, cmd_done, error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  coproc_controller dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_escalar(instr_escalar),
    .instr_addr_a(instr_addr_a), .instr_addr_b(instr_addr_b), .instr_addr_r(instr_addr_r),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ula_start(ula_start), .ula_opcode(ula_opcode), .ula_escalar(ula_escalar),
    .ula_matriz_a(ula_matriz_a), .ula_matriz_b(ula_matriz_b),
    .ula_resultado(ula_resultado), .ula_done(ula_done),
    .busy(busy), .cmd_done(cmd_done), .error(error)
  );

  // ---------------- environment: memory and ULA stand-in ----------------
  logic [7:0] mem [512];
  logic [7:0] img [512];
  logic       load_req = 1'b0;
  logic       ula_en = 1'b1;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= img[i];
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_wdata;
    end
  end

  function automatic logic [7:0] ula_fn(input logic [3:0] op, input logic [7:0] esc,
                                        input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a * esc;
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    ula_resultado = '0;
    for (int k = 0; k < 25; k++)
      ula_resultado[8*k +: 8] = ula_fn(ula_opcode, ula_escalar,
                                       ula_matriz_a[8*k +: 8], ula_matriz_b[8*k +: 8]);
  end

  // ULA answers one cycle after it sees start; done follows start low.
  always @(posedge clk) ula_done <= !reset && ula_start && ula_en;

  // ---------------- reference model ----------------
  // Number of memory bytes differing from the image with the expected result applied.
  function automatic int mem_bad(input logic [3:0] op, input logic [7:0] esc,
                                 input logic [8:0] a, input logic [8:0] b, input logic [8:0] r);
    logic [7:0] exp [512];
    int bad = 0;
    for (int i = 0; i < 512; i++) exp[i] = img[i];
    for (int k = 0; k < 25; k++)
      exp[(int'(r) + k) % 512] = ula_fn(op, esc, img[(int'(a) + k) % 512], img[(int'(b) + k) % 512]);
    for (int i = 0; i < 512; i++) if (mem[i] !== exp[i]) bad++;
    return bad;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 512; i++) img[i] = 8'($urandom);
  endtask

  task automatic load_img();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  // per-instruction observations
  int n_rd, n_wr, n_start, n_both, done_cycle;
  logic err_at_done, err_c1;
  logic [8:0] rd_addrs[$];

  task automatic run_instr(input logic [3:0] op, input logic [7:0] esc, input logic [8:0] a,
                           input logic [8:0] b, input logic [8:0] r, input logic en, input int budget);
    ula_en = en;
    n_rd = 0; n_wr = 0; n_start = 0; n_both = 0; done_cycle = -1;
    err_at_done = 1'bx; err_c1 = 1'bx;
    rd_addrs.delete();
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = op; instr_escalar = esc;
    instr_addr_a = a; instr_addr_b = b; instr_addr_r = r;
    @(posedge clk); #1 instr_valid = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (mem_rd) begin n_rd++; rd_addrs.push_back(mem_addr); end
      if (mem_wr) n_wr++;
      if (ula_start) n_start++;
      if (mem_rd && mem_wr) n_both++;
      if (c == 1) err_c1 = error;
      if (cmd_done) begin done_cycle = c; err_at_done = error; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({instr_ready, busy, mem_rd, mem_wr, ula_start, cmd_done, error} !== 7'b1000000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: rdy/busy/rd/wr/start/done/err=%b want 1000000", i,
                 {instr_ready, busy, mem_rd, mem_wr, ula_start, cmd_done, error});
      end
    end
    checks++;
    if ({ula_matriz_a, ula_matriz_b, ula_opcode, ula_escalar, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_regs: ula/mem outputs not zero after reset");
    end
  endtask

  task automatic test_add();
    fill_random();
    for (int k = 0; k < 25; k++) begin img[k] = 8'(k); img[32 + k] = 8'(2 * k); end
    load_img();
    run_instr(4'd1, 8'd0, 9'h000, 9'h020, 9'h040, 1'b1, 200);
    checks++;
    if (done_cycle != 80) begin errors++; $display("FAIL add_latency: got %0d want 80", done_cycle); end
    checks++;
    if (err_at_done !== 1'b0) begin errors++; $display("FAIL add_error: got %b want 0", err_at_done); end
    checks++;
    if ({n_rd, n_wr, n_start, n_both} != {32'd50, 32'd25, 32'd2, 32'd0}) begin
      errors++; $display("FAIL add_strobes: rd=%0d wr=%0d start=%0d both=%0d want 50 25 2 0",
                         n_rd, n_wr, n_start, n_both);
    end
    @(negedge clk);
    checks++;
    for (int k = 0; k < 25; k++) if (mem[64 + k] !== 8'(3 * k)) begin
      errors++; $display("FAIL add_result: mem[0x%0h]=%0d want %0d", 64 + k, mem[64 + k], 3 * k);
      break;
    end
    checks++;
    if (mem_bad(4'd1, 8'd0, 9'h000, 9'h020, 9'h040) != 0) begin
      errors++; $display("FAIL add_image: %0d bytes wrong, want 0", mem_bad(4'd1, 8'd0, 9'h000, 9'h020, 9'h040));
    end
  endtask

  task automatic test_wrap();
    logic [7:0] esc = 8'($urandom);
    int bad = 0;
    fill_random(); load_img();
    run_instr(4'd3, esc, 9'h1F0, 9'h100, 9'h080, 1'b1, 200);
    for (int k = 0; k < 25; k++)
      if (k >= rd_addrs.size() || rd_addrs[k] !== 9'((32'h1F0 + k) % 512)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_addr: %0d A read addresses wrong, want 0", bad); end
    @(negedge clk);
    checks++;
    if (mem_bad(4'd3, esc, 9'h1F0, 9'h100, 9'h080) != 0) begin
      errors++; $display("FAIL wrap_image: %0d bytes wrong, want 0", mem_bad(4'd3, esc, 9'h1F0, 9'h100, 9'h080));
    end
  endtask

  task automatic test_nop();
    run_instr(4'd0, 8'h55, 9'h011, 9'h022, 9'h033, 1'b1, 20);
    checks++;
    if (done_cycle != 1) begin errors++; $display("FAIL nop_latency: got %0d want 1", done_cycle); end
    checks++;
    if (n_rd + n_wr + n_start != 0) begin
      errors++; $display("FAIL nop_traffic: rd=%0d wr=%0d start=%0d want 0 0 0", n_rd, n_wr, n_start);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] esc = 8'($urandom);
    logic [8:0] a = 9'($urandom), b = 9'($urandom), r = 9'($urandom);
    fill_random(); load_img();
    run_instr(4'd2, 8'd0, 9'h000, 9'h020, 9'h040, 1'b0, 400);
    checks++;
    if (done_cycle != 308) begin errors++; $display("FAIL to_latency: got %0d want 308", done_cycle); end
    checks++;
    if (err_at_done !== 1'b1) begin errors++; $display("FAIL to_error: got %b want 1", err_at_done); end
    checks++;
    if (n_start != 255 || n_wr != 0) begin
      errors++; $display("FAIL to_strobes: start=%0d wr=%0d want 255 0", n_start, n_wr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_hold: error=%b busy=%b want 1 0", error, busy);
    end
    // next accepted instruction clears the flag and runs normally
    run_instr(4'd4, esc, a, b, r, 1'b1, 200);
    checks++;
    if (err_c1 !== 1'b0 || err_at_done !== 1'b0 || done_cycle != 80) begin
      errors++; $display("FAIL to_clear: err_c1=%b err_done=%b cyc=%0d want 0 0 80", err_c1, err_at_done, done_cycle);
    end
  endtask

  task automatic test_reset_store();
    logic [8:0] r = 9'h1F8;
    logic [7:0] esc = 8'($urandom);
    bit hit = 0;
    fill_random(); load_img();
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = 4'd1; instr_escalar = esc;
    instr_addr_a = 9'h000; instr_addr_b = 9'h100; instr_addr_r = r;
    @(posedge clk); #1 instr_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_wr && mem_addr == 9'(r + 9'd10)) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_store_reach: STORE idx 10 not seen, want seen"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wr, mem_rd, busy, instr_ready, ula_start} !== 5'b00010) begin
      errors++; $display("FAIL rst_store_abort: wr/rd/busy/rdy/start=%b want 00010",
                         {mem_wr, mem_rd, busy, instr_ready, ula_start});
    end
    checks++;
    if (ula_matriz_a !== '0 || ula_opcode !== 4'd0) begin
      errors++; $display("FAIL rst_store_clear: opcode=%0d matriz_a nonzero=%b want 0 0", ula_opcode, |ula_matriz_a);
    end
    checks++;
    if (mem[9'(r + 9'd11)] !== img[9'(r + 9'd11)] || mem[9'(r + 9'd10)] !== 8'(img[10] + img[9'h10A])) begin
      errors++; $display("FAIL rst_store_mem: byte10=%0d byte11=%0d want %0d %0d", mem[9'(r + 9'd10)],
                         mem[9'(r + 9'd11)], 8'(img[10] + img[9'h10A]), img[9'(r + 9'd11)]);
    end
    reset = 1'b0;
    fill_random(); load_img();
    run_instr(4'd2, esc, 9'h000, 9'h100, r, 1'b1, 200);
    @(negedge clk);
    checks++;
    if (done_cycle != 80 || mem_bad(4'd2, esc, 9'h000, 9'h100, r) != 0) begin
      errors++; $display("FAIL rst_store_resume: cyc=%0d bad=%0d want 80 0", done_cycle, mem_bad(4'd2, esc, 9'h000, 9'h100, r));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op = 4'($urandom_range(1, 4));
      logic [7:0] esc = 8'($urandom);
      logic [8:0] a = 9'($urandom), b = 9'($urandom), r = 9'($urandom);
      fill_random(); load_img();
      run_instr(op, esc, a, b, r, 1'b1, 200);
      @(negedge clk);
      checks++;
      if (done_cycle != 80 || n_both != 0 || err_at_done !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d_ctrl: cyc=%0d both=%0d err=%b want 80 0 0", i, done_cycle, n_both, err_at_done);
      end
      checks++;
      if (mem_bad(op, esc, a, b, r) != 0) begin
        errors++; $display("FAIL b2b_%0d_image: op=%0d %0d bytes wrong, want 0", i, op, mem_bad(op, esc, a, b, r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_nop();
    test_timeout();
    test_reset_store();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
